// File: rtl/jpeg_buffer_writer.sv
// Repacks the encoder's 128-bit byte-packed beats into 32-bit RAM writes from address 0,
// tracking compressed size, frame completion and buffer overflow.
module jpeg_buffer_writer #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [127:0]  in_data,
  input  logic [4:0]    in_bytes,
  input  logic          in_tlast,
  input  logic          in_valid,
  output logic          in_hold,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic [3:0]    wr_be,
  output logic          wr_en,
  output logic [19:0]   byte_count,
  output logic          done,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [159:0]   r_fifo, w_fifo_nxt, w_comb, w_in_shift;
  logic [4:0]     r_fill, w_fill_nxt, w_avail, w_nb;
  logic [127:0]   w_in_mask;
  logic [AW:0]    r_ptr;
  logic [3:0]     w_part_be;
  logic           w_accept, w_active, w_drain, w_part;

  function automatic logic [19:0] sat_add20(input logic [19:0] a, input logic [4:0] b);
    logic [20:0] s;
    s = {1'b0, a} + {16'b0, b};
    return s[20] ? 20'hFFFFF : s[19:0];
  endfunction

  // Hold depends only on registered state so the encoder never sees a combinational loop.
  assign in_hold  = (r_state != RUN) || (r_fill > 5'd4);
  assign w_accept = in_valid && !in_hold && !start;

  always_comb begin
    w_nb       = (in_bytes > 5'd16) ? 5'd16 : in_bytes;
    w_in_mask  = ~({128{1'b1}} >> {w_nb, 3'b000});
    // Bytes beyond r_fill are always zero, so appending is a shift and OR.
    w_in_shift = {in_data & w_in_mask, 32'h0} >> {r_fill, 3'b000};
    w_comb     = r_fifo | (w_accept ? w_in_shift : 160'h0);
    w_avail    = r_fill + (w_accept ? w_nb : 5'd0);
    w_active   = ((r_state == RUN) || (r_state == FLUSH)) && !start;
    w_drain    = w_active && (w_avail >= 5'd4);
    w_part     = w_active && (r_state == FLUSH) && (w_avail != 5'd0) && (w_avail < 5'd4);
    w_part_be  = {(w_avail >= 5'd1), (w_avail >= 5'd2), (w_avail >= 5'd3), 1'b0};
    w_fifo_nxt = w_comb;
    w_fill_nxt = w_avail;
    if (w_drain) begin
      w_fifo_nxt = w_comb << 32;
      w_fill_nxt = w_avail - 5'd4;
    end else if (w_part) begin
      w_fifo_nxt = 160'h0;
      w_fill_nxt = 5'd0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN:     if (w_accept && in_tlast) w_state_nxt = FLUSH;
        FLUSH:   if (r_fill == 5'd0) w_state_nxt = DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fifo     <= '0;
      r_fill     <= '0;
      r_ptr      <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_be      <= '0;
      wr_en      <= 1'b0;
      byte_count <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        r_fifo     <= '0;
        r_fill     <= '0;
        r_ptr      <= '0;
        wr_addr    <= '0;
        byte_count <= '0;
        done       <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        r_fifo <= w_fifo_nxt;
        r_fill <= w_fill_nxt;
        if (w_accept) byte_count <= sat_add20(byte_count, w_nb);
        // Once the pointer passes the top word, writes are dropped but the FIFO keeps draining.
        if (w_drain || w_part) begin
          if (r_ptr[AW]) begin
            overflow <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= r_ptr[AW-1:0];
            wr_data <= w_comb[159:128];
            wr_be   <= w_drain ? 4'hF : w_part_be;
            r_ptr   <= r_ptr + {{AW{1'b0}}, 1'b1};
          end
        end
        if ((r_state == FLUSH) && (w_state_nxt == DONE)) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_buffer_writer.sv
// Bench for jpeg_buffer_writer: a full-size and a 4-word instance share stimulus and are
// checked against a byte-queue model of the frame.
module tb_jpeg_buffer_writer;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [127:0] in_data = '0;
  logic [4:0]   in_bytes = '0;
  logic         in_tlast = 1'b0;
  logic         in_valid = 1'b0;

  logic        hold_a, en_a, done_a, ovf_a;
  logic [13:0] addr_a;
  logic [31:0] data_a;
  logic [3:0]  be_a;
  logic [19:0] bc_a;
  logic        hold_b, en_b, done_b, ovf_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [3:0]  be_b;
  logic [19:0] bc_b;

  jpeg_buffer_writer #(.AW(14)) dut_a (
    .clk(clk), .resetn(resetn), .start(start), .in_data(in_data), .in_bytes(in_bytes),
    .in_tlast(in_tlast), .in_valid(in_valid), .in_hold(hold_a), .wr_addr(addr_a),
    .wr_data(data_a), .wr_be(be_a), .wr_en(en_a), .byte_count(bc_a), .done(done_a),
    .overflow(ovf_a));

  jpeg_buffer_writer #(.AW(2)) dut_b (
    .clk(clk), .resetn(resetn), .start(start), .in_data(in_data), .in_bytes(in_bytes),
    .in_tlast(in_tlast), .in_valid(in_valid), .in_hold(hold_b), .wr_addr(addr_b),
    .wr_data(data_b), .wr_be(be_b), .wr_en(en_b), .byte_count(bc_b), .done(done_b),
    .overflow(ovf_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } wr_t;

  wr_t        wq_a[$];
  wr_t        wq_b[$];
  logic [7:0] bq[$];
  int         sizes[$];
  int         cyc = 0;
  int         n_err = 0;
  int         n_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en_a) wq_a.push_back('{addr_a, data_a, be_a, cyc});
    if (en_b) wq_b.push_back('{{12'b0, addr_b}, data_b, be_b, cyc});
  end

  task automatic pulse_start();
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input int nb, input bit last, input bit cont);
    int budget;
    budget   = 50;
    in_data  = d;
    in_bytes = nb[4:0];
    in_tlast = last;
    in_valid = 1'b1;
    while (hold_a && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    n_chk++;
    if (budget == 0) begin
      n_err++;
      $display("FAIL beat_accept: in_hold still %b after 50 cycles, want 0", hold_a);
    end
    @(posedge clk); #1;
    if (!cont) begin
      in_valid = 1'b0;
      in_tlast = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_frame(input string name, input bit cont, input bit gapchk);
    logic [127:0] d;
    logic [7:0]   b;
    logic [31:0]  ew;
    logic [3:0]   ebe;
    int n, nw, nwb, done_cyc, budget;
    pulse_start();
    wq_a.delete();
    wq_b.delete();
    bq.delete();
    for (int i = 0; i < sizes.size(); i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < sizes[i]; k++) begin
        b = 8'($urandom);
        d[127-8*k -: 8] = b;
        bq.push_back(b);
      end
      send_beat(d, sizes[i], i == sizes.size() - 1, cont);
    end
    in_valid = 1'b0;
    in_tlast = 1'b0;
    done_cyc = -1;
    budget   = 200;
    while (budget > 0) begin
      @(negedge clk);
      if (done_a) begin
        done_cyc = cyc;
        break;
      end
      budget--;
    end
    @(posedge clk); #1;
    n   = bq.size();
    nw  = (n + 3) / 4;
    nwb = (nw > 4) ? 4 : nw;

    n_chk++;
    if (done_a !== 1'b1 || done_b !== 1'b1) begin
      n_err++;
      $display("FAIL %s done: got %b/%b want 1/1", name, done_a, done_b);
    end
    n_chk++;
    if (wq_a.size() != nw) begin
      n_err++;
      $display("FAIL %s write_count: got %0d want %0d", name, wq_a.size(), nw);
    end
    n_chk++;
    if (wq_b.size() != nwb) begin
      n_err++;
      $display("FAIL %s small_write_count: got %0d want %0d", name, wq_b.size(), nwb);
    end
    for (int i = 0; i < nw; i++) begin
      ew  = '0;
      ebe = '0;
      for (int j = 0; j < 4; j++) begin
        if (4*i + j < n) begin
          ew[31-8*j -: 8] = bq[4*i + j];
          ebe[3-j] = 1'b1;
        end
      end
      if (i < wq_a.size()) begin
        n_chk++;
        if (wq_a[i].addr !== 14'(i) || wq_a[i].data !== ew || wq_a[i].be !== ebe) begin
          n_err++;
          $display("FAIL %s word%0d: got addr=%0d data=%h be=%b want addr=%0d data=%h be=%b",
                   name, i, wq_a[i].addr, wq_a[i].data, wq_a[i].be, i, ew, ebe);
        end
        if (gapchk && i > 0) begin
          n_chk++;
          if (wq_a[i].cyc != wq_a[i-1].cyc + 1) begin
            n_err++;
            $display("FAIL %s gap%0d: write cycle %0d want %0d", name, i, wq_a[i].cyc,
                     wq_a[i-1].cyc + 1);
          end
        end
      end
      if (i < wq_b.size()) begin
        n_chk++;
        if (wq_b[i].addr !== 14'(i) || wq_b[i].data !== ew || wq_b[i].be !== ebe) begin
          n_err++;
          $display("FAIL %s small_word%0d: got addr=%0d data=%h be=%b want addr=%0d data=%h be=%b",
                   name, i, wq_b[i].addr, wq_b[i].data, wq_b[i].be, i, ew, ebe);
        end
      end
    end
    n_chk++;
    if (bc_a !== 20'(n) || bc_b !== 20'(n)) begin
      n_err++;
      $display("FAIL %s byte_count: got %0d/%0d want %0d", name, bc_a, bc_b, n);
    end
    n_chk++;
    if (ovf_a !== 1'b0 || ovf_b !== (nw > 4)) begin
      n_err++;
      $display("FAIL %s overflow: got %b/%b want 0/%b", name, ovf_a, ovf_b, nw > 4);
    end
    n_chk++;
    if (addr_a !== 14'((nw == 0) ? 0 : nw - 1) || addr_b !== 2'((nwb == 0) ? 0 : nwb - 1)) begin
      n_err++;
      $display("FAIL %s final_addr: got %0d/%0d want %0d/%0d", name, addr_a, addr_b,
               (nw == 0) ? 0 : nw - 1, (nwb == 0) ? 0 : nwb - 1);
    end
    if (nw > 0 && wq_a.size() > 0) begin
      n_chk++;
      if (!(done_cyc > wq_a[wq_a.size()-1].cyc)) begin
        n_err++;
        $display("FAIL %s done_order: done cycle %0d, last write cycle %0d", name, done_cyc,
                 wq_a[wq_a.size()-1].cyc);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (hold_a !== 1'b1 || addr_a !== '0 || data_a !== '0 || be_a !== '0 || en_a !== 1'b0 ||
        bc_a !== '0 || done_a !== 1'b0 || ovf_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: hold=%b addr=%0d data=%h be=%b en=%b bc=%0d done=%b ovf=%b",
               hold_a, addr_a, data_a, be_a, en_a, bc_a, done_a, ovf_a);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (hold_a !== 1'b1) begin
      n_err++;
      $display("FAIL idle_hold: got %b want 1", hold_a);
    end
  endtask

  task automatic test_single_beat();
    sizes = '{16};
    run_frame("single16", 1'b0, 1'b0);
  endtask

  task automatic test_odd_beats();
    sizes = '{5, 7, 3};
    run_frame("beats_5_7_3", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sizes = '{16, 16, 16, 16, 16};
    run_frame("back_to_back", 1'b1, 1'b1);
  endtask

  task automatic test_overflow();
    sizes = '{16, 4};
    run_frame("overflow20", 1'b0, 1'b0);
  endtask

  task automatic test_zero_frame();
    sizes = '{0};
    run_frame("zero_frame", 1'b0, 1'b0);
    pulse_start();
    n_chk++;
    if (done_a !== 1'b0 || ovf_b !== 1'b0 || bc_a !== '0) begin
      n_err++;
      $display("FAIL restart_clear: done=%b ovf=%b bc=%0d want 0/0/0", done_a, ovf_b, bc_a);
    end
  endtask

  task automatic test_midframe_start();
    pulse_start();
    wq_a.delete();
    send_beat({$urandom, $urandom, $urandom, $urandom}, 16, 1'b0, 1'b0);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 7, 1'b0, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    n_chk++;
    if (wq_a.size() != 5 || ovf_b !== 1'b1 || bc_a !== 20'd23) begin
      n_err++;
      $display("FAIL midframe_pre: writes=%0d ovf_b=%b bc=%0d want 5/1/23", wq_a.size(), ovf_b, bc_a);
    end
    pulse_start();
    n_chk++;
    if (addr_a !== '0 || addr_b !== '0 || bc_a !== '0 || ovf_b !== 1'b0 || done_a !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_clear: addr=%0d/%0d bc=%0d ovf_b=%b done=%b want 0/0/0/0/0",
               addr_a, addr_b, bc_a, ovf_b, done_a);
    end
    sizes = '{9, 6};
    run_frame("after_restart", 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    pulse_start();
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_bytes = 5'd16;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    n_chk++;
    if (hold_a !== 1'b1 || addr_a !== '0 || data_a !== '0 || be_a !== '0 || en_a !== 1'b0 ||
        bc_a !== '0 || done_a !== 1'b0 || ovf_a !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: hold=%b addr=%0d data=%h be=%b en=%b bc=%0d done=%b ovf=%b",
               hold_a, addr_a, data_a, be_a, en_a, bc_a, done_a, ovf_a);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    sizes = '{11, 16, 2};
    run_frame("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_random_frames();
    string nm;
    for (int f = 0; f < 6; f++) begin
      sizes.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) sizes.push_back(int'($urandom_range(0, 16)));
      nm = $sformatf("random%0d", f);
      run_frame(nm, f[0], 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_odd_beats();
    test_back_to_back();
    test_overflow();
    test_zero_frame();
    test_midframe_start();
    test_async_reset();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jpeg_buffer_writer.md
Name: jpeg_buffer_writer

Overview:
- Sits directly downstream of the JPEG encoder and consumes its 128-bit byte-packed output stream (data, byte count, tlast, valid/hold).
- Repacks the variable-length beats into 32-bit words and writes them to the image buffer RAM from word address 0 upward, using a write-enable/byte-enable port.
- Reports the total compressed size, frame completion and buffer overflow to the capture control logic.

Parameters:
- AW, 14: image buffer word-address width in 32-bit words; capacity 2^AW words.

Ports:
- clk, input, 1: clock.
- resetn, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle pulse; clears all state and arms for a new frame.
- in_data, input, 128: encoded bytes, MSB-first; valid bytes are in_data[127 -: 8*in_bytes].
- in_bytes, input, 5: number of valid bytes in the beat, 0..16.
- in_tlast, input, 1: final beat of the frame.
- in_valid, input, 1: beat valid.
- in_hold, output, 1: backpressure to the encoder.
- wr_addr, output, AW: RAM word address.
- wr_data, output, 32: RAM write data; first byte in [31:24].
- wr_be, output, 4: byte enables; wr_be[3] covers [31:24].
- wr_en, output, 1: RAM write strobe.
- byte_count, output, 20: total bytes accepted this frame.
- done, output, 1: frame fully written; level.
- overflow, output, 1: sticky; at least one byte did not fit.

Behaviour:
- Reset values: in_hold=1, wr_addr=0, wr_data=0, wr_be=0, wr_en=0, byte_count=0, done=0, overflow=0. State is IDLE.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start.
  - RUN -> FLUSH when a beat with in_tlast is accepted.
  - FLUSH -> DONE when the byte FIFO is empty and the last write has issued.
  - DONE -> RUN on start.
- start in any state, including mid-frame: next cycle is RUN with FIFO, address, byte_count, done and overflow cleared. Any beat offered in the start cycle is not accepted.
- Byte FIFO: 20-byte internal shift buffer with fill count 0..20.
- in_hold = 1 in IDLE, FLUSH and DONE, and whenever fill > 4. This is a combinational decode of registered state only, never of in_valid/in_bytes. The rule guarantees fill + 16 <= 20.
- A beat is accepted in any cycle where in_valid && !in_hold.
  - Accepted bytes are appended after existing FIFO contents in MSB-first order.
  - byte_count += in_bytes, saturating at 20'hFFFFF.
- Beats with in_bytes=0 are legal; with in_tlast they only trigger the flush.
- Drain, one word per cycle at most:
  - If fill >= 4: next cycle wr_en=1, wr_be=4'hF, the oldest 4 bytes go on wr_data, and fill -= 4.
  - Drain and accept in the same cycle: the drain removes the oldest bytes; the new bytes are appended after the remainder.
- Flush: in FLUSH with 0 < fill < 4, emit one partial word.
  - Valid bytes are left-aligned, unused low bytes are zero.
  - wr_be has the top fill bits set (fill=1 -> 1000, 2 -> 1100, 3 -> 1110).
  - fill then becomes 0.
- Latency: a word completed by a beat accepted in cycle N appears on wr_* in cycle N+1. All wr_* outputs are registered.
- wr_en is a single-cycle strobe per word. Outside write cycles: wr_data and wr_be hold their last values and wr_en=0.
- wr_addr: starts at 0 and increments by 1 after each issued write.
- Overflow:
  - A write whose address would be 2^AW is suppressed (wr_en stays 0) and overflow is set; it stays set until start or reset.
  - wr_addr saturates at 2^AW-1.
  - The FIFO keeps draining and accepting so the encoder is never stalled permanently.
  - byte_count keeps counting.
- done: set on entry to DONE, cleared only by start or reset. A frame with zero total bytes reaches DONE with no writes.
- Throughput: sustains 4 bytes/cycle. in_hold throttles 16-byte beats to one every 4 cycles.
- Reset mid-operation: all outputs return to reset values asynchronously, and FIFO contents are discarded.

Test Plan:
- start, then one beat in_bytes=16, data 00..0F, tlast -> four writes at addr 0..3: 00010203, 04050607, 08090A0B, 0C0D0E0F; be=F each; byte_count=16; done=1 after the last write.
- start, beats of 5, 7, 3 bytes with tlast on the last -> writes at addr 0..3 with the last word partial, wr_be=1110; byte_count=15; byte order preserved across beat boundaries.
- Continuous 16-byte beats with in_valid held high -> in_hold asserts while fill>4; exactly one write per cycle with no gaps once primed; no byte lost or duplicated (scoreboard).
- AW=2, 20-byte frame -> writes at addr 0..3 only; overflow=1; wr_addr stays 3; byte_count=20; done=1.
- Single beat in_bytes=0 with tlast -> no wr_en; done=1; byte_count=0. A second start then clears done and overflow.
- start asserted mid-frame (fill=3) -> FIFO discarded, wr_addr=0, byte_count=0; the next frame's data is written from addr 0 uncorrupted. Async resetn low mid-write -> all outputs return to reset values immediately.
